// File: rtl/exe_stage_div_if.sv
// ID->EXE handshake and instruction bundle.
// master: ID stage (drives valid and the bundle), slave: EXE stage (drives allowin).
interface exe_stage_div_if;
   logic        id_to_exe_valid;
   logic        exe_allowin;
   logic [31:0] id_pc;
   logic [5:0]  id_rf_all;        // {rf_we, rf_waddr[4:0]}
   logic [75:0] id_alu_data_all;  // {alu_op[11:0], src1[31:0], src2[31:0]}
   logic [2:0]  id_div_op;        // {is_div, is_signed, want_rem}
   logic        id_res_from_mem;
   logic        id_mem_we;
   logic [31:0] id_rkd_value;

   modport master (
      output id_to_exe_valid, id_pc, id_rf_all, id_alu_data_all,
             id_div_op, id_res_from_mem, id_mem_we, id_rkd_value,
      input  exe_allowin
   );

   modport slave (
      input  id_to_exe_valid, id_pc, id_rf_all, id_alu_data_all,
             id_div_op, id_res_from_mem, id_mem_we, id_rkd_value,
      output exe_allowin
   );
endinterface

// File: rtl/exe_stage_div.sv
// EXE pipeline stage with an iterative radix-2 restoring divider
// (div.w / mod.w / div.wu / mod.wu). Non-divide instructions pass through
// with no added latency using the external combinational ALU.
// Optional feature macro: DIV_EARLY_ZERO_EN -- divide-by-zero and signed
// overflow finish straight from IDLE instead of running all iterations.
module exe_stage_div #(
   parameter int DIV_ITER = 32   // one quotient bit per cycle; equals datapath width
) (
   input  logic                 clk,
   input  logic                 resetn,
   exe_stage_div_if.slave       id_bus,
   output logic [11:0]          exe_alu_op,
   output logic [31:0]          exe_alu_src1,
   output logic [31:0]          exe_alu_src2,
   input  logic [31:0]          alu_result,
   input  logic                 mem_allowin,
   output logic                 exe_to_mem_valid,
   output logic                 exe_valid,
   output logic [31:0]          exe_pc,
   output logic [31:0]          exe_result,
   output logic [5:0]           exe_rf_all,
   output logic                 exe_res_from_mem,
   output logic                 exe_mem_we,
   output logic [31:0]          exe_rkd_value,
   output logic [38:0]          exe_fwd_all
);

   localparam int CNT_W = $clog2(DIV_ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   // bundle registers
   logic        exe_valid_reg;
   logic [31:0] pc_reg;
   logic [5:0]  rf_all_reg;
   logic [11:0] alu_op_reg;
   logic [31:0] alu_src1_reg;
   logic [31:0] alu_src2_reg;
   logic [2:0]  div_op_reg;
   logic        res_from_mem_reg;
   logic        mem_we_reg;
   logic [31:0] rkd_value_reg;

   // divider state
   div_state_t  state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [31:0] div_rem_reg;     // partial remainder
   logic [31:0] div_quo_reg;     // dividend bits shifted out, quotient bits shifted in
   logic [31:0] div_dvs_reg;     // divisor magnitude
   logic        quo_neg_reg;
   logic        rem_neg_reg;
   logic [31:0] div_result_reg;

   logic is_div, is_signed, want_rem;
   logic ready_go, allowin, handoff, capture;

   assign is_div    = div_op_reg[2];
   assign is_signed = div_op_reg[1];
   assign want_rem  = div_op_reg[0];

   assign ready_go         = ~is_div | (state_reg == DONE);
   assign allowin          = ~exe_valid_reg | (ready_go & mem_allowin);
   assign exe_to_mem_valid = exe_valid_reg & ready_go;
   assign handoff          = exe_to_mem_valid & mem_allowin;
   assign capture          = id_bus.id_to_exe_valid & allowin;
   assign id_bus.exe_allowin = allowin;

   // operand magnitudes and result signs, latched when a divide starts
   logic        src1_neg, src2_neg;
   logic [31:0] src1_mag, src2_mag;
   assign src1_neg = is_signed & alu_src1_reg[31];
   assign src2_neg = is_signed & alu_src2_reg[31];
   assign src1_mag = src1_neg ? (~alu_src1_reg + 32'd1) : alu_src1_reg;
   assign src2_mag = src2_neg ? (~alu_src2_reg + 32'd1) : alu_src2_reg;

   // one restoring step; the borrow bit of the 33-bit difference decides the quotient bit
   logic [32:0] rem_sh, diff;
   logic        sub_ok;
   logic [31:0] rem_step, quo_step, rem_fix, quo_fix;
   assign rem_sh   = {div_rem_reg, div_quo_reg[31]};
   assign diff     = rem_sh - {1'b0, div_dvs_reg};
   assign sub_ok   = ~diff[32];
   assign rem_step = sub_ok ? diff[31:0] : rem_sh[31:0];
   assign quo_step = {div_quo_reg[30:0], sub_ok};
   assign rem_fix  = rem_neg_reg ? (~rem_step + 32'd1) : rem_step;
   assign quo_fix  = quo_neg_reg ? (~quo_step + 32'd1) : quo_step;

`ifdef DIV_EARLY_ZERO_EN
   logic        early_zero, early_ovf, early_hit;
   logic [31:0] early_result;
   assign early_zero   = (alu_src2_reg == 32'd0);
   assign early_ovf    = is_signed & (alu_src1_reg == 32'h8000_0000) & (alu_src2_reg == 32'hFFFF_FFFF);
   assign early_hit    = early_zero | early_ovf;
   assign early_result = early_zero ? (want_rem ? alu_src1_reg : 32'hFFFF_FFFF)
                                    : (want_rem ? 32'd0 : 32'h8000_0000);
`endif

   // stage occupancy and bundle capture; bundle holds unless a new instruction is accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exe_valid_reg    <= 1'b0;
         pc_reg           <= '0;
         rf_all_reg       <= '0;
         alu_op_reg       <= '0;
         alu_src1_reg     <= '0;
         alu_src2_reg     <= '0;
         div_op_reg       <= '0;
         res_from_mem_reg <= 1'b0;
         mem_we_reg       <= 1'b0;
         rkd_value_reg    <= '0;
      end else begin
         if (allowin) exe_valid_reg <= id_bus.id_to_exe_valid;
         if (capture) begin
            pc_reg           <= id_bus.id_pc;
            rf_all_reg       <= id_bus.id_rf_all;
            alu_op_reg       <= id_bus.id_alu_data_all[75:64];
            alu_src1_reg     <= id_bus.id_alu_data_all[63:32];
            alu_src2_reg     <= id_bus.id_alu_data_all[31:0];
            div_op_reg       <= id_bus.id_div_op;
            res_from_mem_reg <= id_bus.id_res_from_mem;
            mem_we_reg       <= id_bus.id_mem_we;
            rkd_value_reg    <= id_bus.id_rkd_value;
         end
      end
   end

   // divider FSM: IDLE latches operands, BUSY iterates, DONE holds the signed-fixed result
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         div_rem_reg    <= '0;
         div_quo_reg    <= '0;
         div_dvs_reg    <= '0;
         quo_neg_reg    <= 1'b0;
         rem_neg_reg    <= 1'b0;
         div_result_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (exe_valid_reg & is_div) begin
                  cnt_reg     <= '0;
                  div_rem_reg <= '0;
                  div_quo_reg <= src1_mag;
                  div_dvs_reg <= src2_mag;
                  // a zero divisor yields an all-ones quotient regardless of signs
                  quo_neg_reg <= (src1_neg ^ src2_neg) & (alu_src2_reg != 32'd0);
                  rem_neg_reg <= src1_neg;
`ifdef DIV_EARLY_ZERO_EN
                  if (early_hit) begin
                     div_result_reg <= early_result;
                     state_reg      <= DONE;
                  end else begin
                     state_reg      <= BUSY;
                  end
`else
                  state_reg   <= BUSY;
`endif
               end
            end
            BUSY: begin
               div_rem_reg <= rem_step;
               div_quo_reg <= quo_step;
               cnt_reg     <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_LAST) begin
                  div_result_reg <= want_rem ? rem_fix : quo_fix;
                  state_reg      <= DONE;
               end
            end
            DONE: begin
               if (handoff) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign exe_valid        = exe_valid_reg;
   assign exe_pc           = pc_reg;
   assign exe_rf_all       = rf_all_reg;
   assign exe_alu_op       = alu_op_reg;
   assign exe_alu_src1     = alu_src1_reg;
   assign exe_alu_src2     = alu_src2_reg;
   assign exe_res_from_mem = res_from_mem_reg;
   assign exe_mem_we       = mem_we_reg;
   assign exe_rkd_value    = rkd_value_reg;
   assign exe_result       = is_div ? div_result_reg : alu_result;
   assign exe_fwd_all      = {exe_valid_reg & (res_from_mem_reg | (is_div & (state_reg != DONE))),
                              rf_all_reg, exe_result};

endmodule

// File: tb/tb_exe_stage_div.sv
// Testbench for exe_stage_div: directed vectors, scoreboard queue filled at
// issue time and drained by an independent output monitor.
module tb_exe_stage_div;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   exe_stage_div_if id_bus();

   logic [11:0] exe_alu_op;
   logic [31:0] exe_alu_src1, exe_alu_src2, alu_result;
   logic        mem_allowin;
   logic        exe_to_mem_valid, exe_valid;
   logic [31:0] exe_pc, exe_result, exe_rkd_value;
   logic [5:0]  exe_rf_all;
   logic        exe_res_from_mem, exe_mem_we;
   logic [38:0] exe_fwd_all;

   exe_stage_div dut (
      .clk(clk), .resetn(resetn), .id_bus(id_bus.slave),
      .exe_alu_op(exe_alu_op), .exe_alu_src1(exe_alu_src1), .exe_alu_src2(exe_alu_src2),
      .alu_result(alu_result), .mem_allowin(mem_allowin),
      .exe_to_mem_valid(exe_to_mem_valid), .exe_valid(exe_valid), .exe_pc(exe_pc),
      .exe_result(exe_result), .exe_rf_all(exe_rf_all), .exe_res_from_mem(exe_res_from_mem),
      .exe_mem_we(exe_mem_we), .exe_rkd_value(exe_rkd_value), .exe_fwd_all(exe_fwd_all)
   );

   // external ALU: bit0 add, bit1 sub
   localparam logic [11:0] OP_ADD = 12'h001;
   localparam logic [11:0] OP_SUB = 12'h002;
   always_comb begin
      alu_result = 32'd0;
      if (exe_alu_op[0])      alu_result = exe_alu_src1 + exe_alu_src2;
      else if (exe_alu_op[1]) alu_result = exe_alu_src1 - exe_alu_src2;
   end

   localparam logic [2:0] NODIV = 3'b000, DIVWU = 3'b100, MODWU = 3'b101, DIVW = 3'b110, MODW = 3'b111;
   localparam int DL = 34;
`ifdef DIV_EARLY_ZERO_EN
   localparam int EL = 2;
`else
   localparam int EL = 34;
`endif

   typedef struct { logic [31:0] pc; logic [31:0] result; logic [5:0] rf; } exp_t;
   exp_t sb[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // output monitor: every handoff to MEM must match the oldest issued instruction
   always @(negedge clk) begin
      if (resetn && exe_to_mem_valid && mem_allowin) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got pc %h with no instruction outstanding", exe_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("[TB] out pc=%h result=%h expected=%h", exe_pc, exe_result, e.result);
            check("out_pc", 64'(exe_pc), 64'(e.pc));
            check("out_result", 64'(exe_result), 64'(e.result));
            check("fwd_result", 64'(exe_fwd_all[31:0]), 64'(e.result));
            check("out_rf", 64'(exe_rf_all), 64'(e.rf));
         end
      end
   end

   // drive a bundle (caller sits just after a posedge), wait until it is accepted
   task automatic send(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] dop, input logic ld,
                       input logic [5:0] rf, input logic [31:0] exp);
      int g;
      id_bus.id_to_exe_valid = 1'b1;
      id_bus.id_pc           = pc;
      id_bus.id_rf_all       = rf;
      id_bus.id_alu_data_all = {op, a, b};
      id_bus.id_div_op       = dop;
      id_bus.id_res_from_mem = ld;
      id_bus.id_mem_we       = 1'b0;
      id_bus.id_rkd_value    = pc ^ 32'h5A5A_5A5A;
      g = 0;
      forever begin
         @(negedge clk);
         if (id_bus.exe_allowin) break;
         g++;
         if (g >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: got allowin=0 for %0d cycles required 1", g);
            break;
         end
      end
      @(posedge clk); #1;
      id_bus.id_to_exe_valid = 1'b0;
      sb.push_back('{pc, exp, rf});
   endtask

   // issue, then measure cycles until the stage offers the instruction to MEM
   task automatic run_op(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] dop, input logic ld,
                         input logic [31:0] exp, input int lat, input logic stall_end);
      int  n;
      logic stall_ok;
      send(pc, op, a, b, dop, ld, 6'h20 | 6'(pc[6:2]), exp);
      n = 1;
      stall_ok = 1'b1;
      @(negedge clk);
      while (!exe_to_mem_valid && n < 100) begin
         if (!exe_fwd_all[38]) stall_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(lat));
      check("stall_while_busy", 64'(stall_ok), 64'd1);
      check("stall_at_output", 64'(exe_fwd_all[38]), 64'(stall_end));
      check("rkd_value", 64'(exe_rkd_value), 64'(pc ^ 32'h5A5A_5A5A));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      id_bus.id_to_exe_valid = 1'b0;
      id_bus.id_pc = '0; id_bus.id_rf_all = '0; id_bus.id_alu_data_all = '0;
      id_bus.id_div_op = '0; id_bus.id_res_from_mem = 1'b0; id_bus.id_mem_we = 1'b0;
      id_bus.id_rkd_value = '0;
      mem_allowin = 1'b1;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(exe_valid), 64'd0);
      check("rst_to_mem_valid", 64'(exe_to_mem_valid), 64'd0);
      check("rst_pc", 64'(exe_pc), 64'd0);
      check("rst_fwd", 64'(exe_fwd_all), 64'd0);
      check("rst_alu", 64'({exe_alu_op, exe_alu_src1}), 64'd0);
      check("rst_misc", 64'({exe_rf_all, exe_res_from_mem, exe_mem_we, exe_rkd_value}), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // pass-through and load stall
      run_op(32'h100, OP_ADD, 32'd3, 32'd4, NODIV, 1'b0, 32'd7, 1, 1'b0);
      run_op(32'h104, OP_SUB, 32'd10, 32'd15, NODIV, 1'b0, 32'hFFFF_FFFB, 1, 1'b0);
      run_op(32'h108, OP_ADD, 32'd8, 32'd4, NODIV, 1'b1, 32'd12, 1, 1'b1);
      // unsigned
      run_op(32'h10C, OP_ADD, 32'd100, 32'd7, DIVWU, 1'b0, 32'd14, DL, 1'b0);
      run_op(32'h110, OP_ADD, 32'd100, 32'd7, MODWU, 1'b0, 32'd2, DL, 1'b0);
      run_op(32'h114, OP_ADD, 32'hFFFF_FFFF, 32'd1, DIVWU, 1'b0, 32'hFFFF_FFFF, DL, 1'b0);
      // signed
      run_op(32'h118, OP_ADD, 32'hFFFF_FFF9, 32'd2, DIVW, 1'b0, 32'hFFFF_FFFD, DL, 1'b0);
      run_op(32'h11C, OP_ADD, 32'hFFFF_FFF9, 32'd2, MODW, 1'b0, 32'hFFFF_FFFF, DL, 1'b0);
      run_op(32'h120, OP_ADD, 32'd7, 32'hFFFF_FFFE, DIVW, 1'b0, 32'hFFFF_FFFD, DL, 1'b0);
      run_op(32'h124, OP_ADD, 32'd7, 32'hFFFF_FFFE, MODW, 1'b0, 32'd1, DL, 1'b0);
      run_op(32'h128, OP_ADD, 32'hFFFF_FFFA, 32'hFFFF_FFFD, DIVW, 1'b0, 32'd2, DL, 1'b0);
      // overflow and divide by zero
      run_op(32'h12C, OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, DIVW, 1'b0, 32'h8000_0000, EL, 1'b0);
      run_op(32'h130, OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, MODW, 1'b0, 32'd0, EL, 1'b0);
      run_op(32'h134, OP_ADD, 32'd5, 32'd0, DIVW, 1'b0, 32'hFFFF_FFFF, EL, 1'b0);
      run_op(32'h138, OP_ADD, 32'd5, 32'd0, MODW, 1'b0, 32'd5, EL, 1'b0);
      run_op(32'h13C, OP_ADD, 32'hFFFF_FFF9, 32'd0, DIVW, 1'b0, 32'hFFFF_FFFF, EL, 1'b0);
      run_op(32'h140, OP_ADD, 32'hFFFF_FFF9, 32'd0, MODW, 1'b0, 32'hFFFF_FFF9, EL, 1'b0);
      run_op(32'h144, OP_ADD, 32'hFFFF_FFF0, 32'd0, MODWU, 1'b0, 32'hFFFF_FFF0, EL, 1'b0);
      run_op(32'h148, OP_ADD, 32'd7, 32'd0, DIVWU, 1'b0, 32'hFFFF_FFFF, EL, 1'b0);

      // back-pressure while DONE
      mem_allowin = 1'b0;
      send(32'h200, OP_ADD, 32'd100, 32'd7, DIVWU, 1'b0, 6'h21, 32'd14);
      n = 0;
      while (!exe_to_mem_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_reach_done", 64'(exe_to_mem_valid), 64'd1);
      @(posedge clk); #1;
      id_bus.id_to_exe_valid = 1'b1;
      id_bus.id_pc = 32'h300;
      id_bus.id_alu_data_all = {OP_ADD, 32'd1, 32'd1};
      id_bus.id_div_op = NODIV;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_result", 64'(exe_result), 64'd14);
         check("bp_pc", 64'(exe_pc), 64'h200);
         check("bp_allowin", 64'(id_bus.exe_allowin), 64'd0);
         check("bp_valid", 64'({exe_to_mem_valid, exe_fwd_all[38]}), 64'b10);
         check("bp_src1", 64'(exe_alu_src1), 64'd100);
      end
      @(posedge clk); #1;
      mem_allowin = 1'b1;
      run_op(32'h300, OP_ADD, 32'd1, 32'd1, NODIV, 1'b0, 32'd2, 1, 1'b0);
      run_op(32'h304, OP_ADD, 32'd100, 32'd7, MODWU, 1'b0, 32'd2, DL, 1'b0);

      // reset in the middle of BUSY
      send(32'h400, OP_ADD, 32'd100, 32'd7, DIVWU, 1'b0, 6'h22, 32'd14);
      repeat (10) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", 64'(exe_valid), 64'd0);
      check("mid_rst_out", 64'({exe_to_mem_valid, exe_fwd_all[38]}), 64'd0);
      check("mid_rst_pc", 64'(exe_pc), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      run_op(32'h410, OP_ADD, 32'hFFFF_FFF9, 32'd2, DIVW, 1'b0, 32'hFFFF_FFFD, DL, 1'b0);

      repeat (3) @(posedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
